cwalk_ctrl_param: RTL and testbench

- Parametrised pedestrian-crossing controller.
- Replaces the fixed-timing crosswalk FSM, which needed an external countdown counter fed back through c7/tc.
- Contains its own walk timer and countdown counter, and adds on-demand request latching, a flashing-hand phase and a completion handshake.
- Sits beside the traffic-light FSM: that FSM grants a crossing window with `start` and waits for `done`. The timebase comes from the shared 1 Hz `tick` divider.

---
 rtl/cwalk_ctrl_param.sv | 127 ++++++++++++
 tb/tb_cwalk_ctrl_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cwalk_ctrl_param.sv
// Pedestrian-crossing controller with internal walk timer, flashing-hand countdown and done handshake.
// Latency: Moore, every output registered; WALK entered one clk after a qualified start.
// Backpressure: none; start is only honoured in IDLE and is never queued.
module cwalk_ctrl_param #(
    parameter int CNT_W       = 4,
    parameter int WALK_TICKS  = 5,
    parameter int FLASH_TICKS = 9,
    parameter int ON_DEMAND   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             ped_req,
    output logic             walk,
    output logic             hand,
    output logic             num_on,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             req_pending
);

    localparam int TW = (WALK_TICKS < 1) ? 1 : $clog2(WALK_TICKS + 1);
    localparam logic OD = (ON_DEMAND != 0);

    if (WALK_TICKS < 1) begin : g_bad_walk
        $fatal(1, "cwalk_ctrl_param: WALK_TICKS must be >= 1");
    end
    if (FLASH_TICKS < 0 || FLASH_TICKS >= (1 << CNT_W)) begin : g_bad_flash
        $fatal(1, "cwalk_ctrl_param: FLASH_TICKS must fit in CNT_W bits");
    end

    typedef enum logic [1:0] {IDLE, WALK, FLASH, DONE} state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] count_q;
    logic             phase_q;
    logic             req_q;
    logic             walk_q;
    logic             hand_q;
    logic             num_on_q;
    logic             busy_q;
    logic             done_q;
    logic             go_d;

    // A request arriving together with start still qualifies the crossing.
    assign go_d = start & (~OD | req_q | ped_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            phase_q  <= 1'b1;
            req_q    <= 1'b0;
            walk_q   <= 1'b0;
            hand_q   <= 1'b1;
            num_on_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_d) begin
                        state_q <= WALK;
                        timer_q <= TW'(WALK_TICKS);
                        req_q   <= 1'b0;
                        walk_q  <= 1'b1;
                        hand_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (ped_req) begin
                        req_q <= 1'b1;
                    end
                end
                WALK: begin
                    // ped_req is deliberately ignored: this pedestrian is being served.
                    if (tick) begin
                        timer_q <= timer_q - TW'(1);
                        if (timer_q == TW'(1)) begin
                            state_q  <= FLASH;
                            count_q  <= CNT_W'(FLASH_TICKS);
                            phase_q  <= 1'b1;
                            walk_q   <= 1'b0;
                            hand_q   <= 1'b1;
                            num_on_q <= 1'b1;
                        end
                    end
                end
                FLASH: begin
                    if (ped_req) req_q <= 1'b1;
                    if (tick) begin
                        if (count_q == '0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            hand_q   <= 1'b1;
                            num_on_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end else begin
                            count_q <= count_q - CNT_W'(1);
                            phase_q <= ~phase_q;
                            hand_q  <= ~phase_q;
                        end
                    end
                end
                DONE: begin
                    if (ped_req) req_q <= 1'b1;
                    state_q <= IDLE;
                    count_q <= '0;
                    hand_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign walk        = walk_q;
    assign hand        = hand_q;
    assign num_on      = num_on_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_cwalk_ctrl_param.sv
// Directed-vector bench for cwalk_ctrl_param: default on-demand instance plus a minimal always-cross instance.
module tb_cwalk_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick, start, ped_req;
    logic       walk, hand, num_on, busy, done, req_pending;
    logic [3:0] count;

    logic       tick2, start2, ped2;
    logic       walk2, hand2, num_on2, busy2, done2, req2;
    logic [1:0] count2;

    cwalk_ctrl_param dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .ped_req(ped_req),
        .walk(walk), .hand(hand), .num_on(num_on), .count(count),
        .busy(busy), .done(done), .req_pending(req_pending)
    );

    cwalk_ctrl_param #(.CNT_W(2), .WALK_TICKS(1), .FLASH_TICKS(0), .ON_DEMAND(0)) dut2 (
        .clk(clk), .reset(reset), .tick(tick2), .start(start2), .ped_req(ped2),
        .walk(walk2), .hand(hand2), .num_on(num_on2), .count(count2),
        .busy(busy2), .done(done2), .req_pending(req2)
    );

    typedef struct {
        logic       tk, st, pr;
        logic       w, h, n;
        logic [3:0] c;
        logic       b, d, rp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act[9:0], exp[9:0]);
        end
    endtask

    function automatic void add(input logic tk, st, pr, w, h, n, input logic [3:0] c,
                                input logic b, d, rp);
        vec_t v;
        v.tk = tk; v.st = st; v.pr = pr;
        v.w = w; v.h = h; v.n = n; v.c = c; v.b = b; v.d = d; v.rp = rp;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] outs1();
        return {22'd0, walk, hand, num_on, count, busy, done, req_pending};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] k4;
        int         dones;

        // crossing 1: request latched, start 3 clks later, tick gap inside WALK, start ignored in FLASH
        add(0,0,1, 0,1,0,4'd0,0,0,1);
        add(0,0,0, 0,1,0,4'd0,0,0,1);
        add(0,0,0, 0,1,0,4'd0,0,0,1);
        add(0,1,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(0,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 0,1,1,4'd9,1,0,0);
        for (int k = 8; k >= 0; k--) begin
            k4 = 4'(k);
            add(1, (k == 4), 0, 0, k4[0], 1, k4, 1, 0, 0);
        end
        add(1,0,0, 0,1,0,4'd0,0,1,0);
        add(0,0,0, 0,1,0,4'd0,0,0,0);
        // crossing 2: same-cycle request+start, request in WALK ignored, request in FLASH latched
        add(0,1,1, 1,0,0,4'd0,1,0,0);
        add(0,0,1, 1,0,0,4'd0,1,0,0);
        add(1,0,1, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 1,0,0,4'd0,1,0,0);
        add(1,0,0, 0,1,1,4'd9,1,0,0);
        add(0,0,1, 0,1,1,4'd9,1,0,1);
        for (int k = 8; k >= 0; k--) begin
            k4 = 4'(k);
            add(1, 0, 0, 0, k4[0], 1, k4, 1, 0, 1);
        end
        add(1,0,0, 0,1,0,4'd0,0,1,1);
        add(0,0,0, 0,1,0,4'd0,0,0,1);
        add(0,1,0, 1,0,0,4'd0,1,0,0);

        reset = 1'b1; tick = 1'b0; start = 1'b0; ped_req = 1'b0;
        tick2 = 1'b0; start2 = 1'b0; ped2 = 1'b0;
        step();
        chk("reset_state", outs1(), {22'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        chk("reset_state2", {22'd0, walk2, hand2, num_on2, 2'b00, count2, busy2, done2, req2},
            {22'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;

        // on-demand with no request: start alone never crosses
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("no_req_idle_%0d", i), outs1(),
                {22'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        end
        start = 1'b0;

        foreach (vecs[i]) begin
            tick = vecs[i].tk; start = vecs[i].st; ped_req = vecs[i].pr;
            step();
            chk($sformatf("vec%0d", i), outs1(),
                {22'd0, vecs[i].w, vecs[i].h, vecs[i].n, vecs[i].c, vecs[i].b, vecs[i].d, vecs[i].rp});
        end
        tick = 1'b0; start = 1'b0; ped_req = 1'b0;

        // async reset in WALK (the third tick is pending when reset hits)
        reset = 1'b1; #2; reset = 1'b0;
        ped_req = 1'b1; start = 1'b1;
        step();
        chk("rst_walk_entry", {31'd0, walk}, 32'd1);
        ped_req = 1'b0; start = 1'b0; tick = 1'b1;
        step();
        step();
        #3 reset = 1'b1;
        #1;
        chk("rst_walk_async", {22'd0, walk, hand, num_on, count, busy, done, req_pending},
            {22'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        tick = 1'b0;
        step();
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_idle_%0d", i), {30'd0, walk, req_pending}, 32'd0);
        end
        ped_req = 1'b1;
        step();
        chk("post_rst_walk", {31'd0, walk}, 32'd1);
        ped_req = 1'b0; start = 1'b0; tick = 1'b1;
        repeat (5) step();
        chk("flash_before_rst", {26'd0, num_on, count, walk}, {26'd0, 1'b1, 4'd9, 1'b0});
        tick = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rst_flash_async", outs1(), {22'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        step();
        reset = 1'b0;

        // always-cross instance: 4-clk loop IDLE->WALK->FLASH->DONE with start held
        tick2 = 1'b1; start2 = 1'b1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            logic [31:0] exp2;
            step();
            case (i % 4)
                1:       exp2 = {22'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0};
                2:       exp2 = {22'd0, 1'b0, 1'b1, 1'b1, 2'b00, 2'd0, 1'b1, 1'b0, 1'b0};
                3:       exp2 = {22'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0};
                default: exp2 = {22'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0};
            endcase
            if (done2) dones++;
            chk($sformatf("loop_%0d", i), {22'd0, walk2, hand2, num_on2, 2'b00, count2, busy2, done2, req2},
                exp2);
        end
        chk("loop_done_count", 32'(dones), 32'd3);
        tick2 = 1'b0; start2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
